// File: rtl/aes_core_ctrl.sv
// Round-sequencing controller for the AES core: command acceptance, key-expansion and round sequencing.
// Defining AES_CTRL_CNT_EN adds the CNT_W parameter and a wrapping completed-block counter on blk_count.
module aes_core_ctrl
`ifdef AES_CTRL_CNT_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init,
  input  logic             next,
  input  logic             encdec,
  input  logic [3:0]       keylen,
  output logic             ready,
  output logic             key_valid,
  output logic             result_valid,
  output logic             cmd_err,
  output logic             kexp_en,
  output logic [3:0]       kexp_idx,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic             dp_final,
  output logic             dp_encdec,
  output logic [3:0]       round_idx
`ifdef AES_CTRL_CNT_EN
  ,
  output logic [CNT_W-1:0] blk_count
`endif
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] NR_128 = IDX_W'(10);
  localparam logic [IDX_W-1:0] NR_192 = IDX_W'(12);
  localparam logic [IDX_W-1:0] NR_256 = IDX_W'(14);
  localparam logic [1:0]       KEYLEN_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    LOAD  = 2'd2,
    ROUND = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] nr, nr_d;
  logic [IDX_W-1:0] rnd_cnt, rnd_cnt_d;

  logic             ready_d;
  logic             key_valid_d;
  logic             result_valid_d;
  logic             cmd_err_d;
  logic             kexp_en_d;
  logic [IDX_W-1:0] kexp_idx_d;
  logic             dp_load_d;
  logic             dp_round_en_d;
  logic             dp_final_d;
  logic             dp_encdec_d;
  logic [IDX_W-1:0] round_idx_d;

`ifdef AES_CTRL_CNT_EN
  logic [CNT_W-1:0] blk_count_d;
`endif

  // Only the low two keylen bits select the key size.
  logic unused_keylen_hi;
  assign unused_keylen_hi = ^keylen[3:2];

  function automatic logic [IDX_W-1:0] decode_nr(input logic [1:0] kl);
    case (kl)
      2'd0:    return NR_128;
      2'd1:    return NR_192;
      default: return NR_256;
    endcase
  endfunction

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d        = state;
    nr_d           = nr;
    rnd_cnt_d      = rnd_cnt;
    ready_d        = ready;
    key_valid_d    = key_valid;
    result_valid_d = 1'b0;
    cmd_err_d      = 1'b0;
    kexp_en_d      = 1'b0;
    kexp_idx_d     = kexp_idx;
    dp_load_d      = 1'b0;
    dp_round_en_d  = 1'b0;
    dp_final_d     = 1'b0;
    dp_encdec_d    = dp_encdec;
    round_idx_d    = round_idx;
`ifdef AES_CTRL_CNT_EN
    blk_count_d    = blk_count;
`endif

    case (state)
      IDLE: begin
        ready_d = 1'b1;
        // init takes priority; a simultaneous next is dropped without error.
        if (init) begin
          if (keylen[1:0] != KEYLEN_ILLEGAL) begin
            nr_d        = decode_nr(keylen[1:0]);
            key_valid_d = 1'b0;
            ready_d     = 1'b0;
            kexp_en_d   = 1'b1;
            kexp_idx_d  = '0;
            state_d     = KEXP;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else if (next) begin
          if (key_valid) begin
            dp_encdec_d = encdec;
            ready_d     = 1'b0;
            dp_load_d   = 1'b1;
            round_idx_d = encdec ? '0 : nr;
            state_d     = LOAD;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      KEXP: begin
        if (kexp_idx == nr) begin
          key_valid_d = 1'b1;
          ready_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          kexp_en_d  = 1'b1;
          kexp_idx_d = kexp_idx + IDX_W'(1);
        end
      end

      LOAD: begin
        dp_round_en_d = 1'b1;
        rnd_cnt_d     = IDX_W'(1);
        round_idx_d   = dp_encdec ? IDX_W'(1) : (nr - IDX_W'(1));
        dp_final_d    = (nr == IDX_W'(1));
        state_d       = ROUND;
      end

      ROUND: begin
        if (rnd_cnt == nr) begin
          result_valid_d = 1'b1;
          ready_d        = 1'b1;
          state_d        = IDLE;
`ifdef AES_CTRL_CNT_EN
          blk_count_d    = blk_count + CNT_W'(1);
`endif
        end else begin
          dp_round_en_d = 1'b1;
          rnd_cnt_d     = rnd_cnt + IDX_W'(1);
          round_idx_d   = dp_encdec ? (round_idx + IDX_W'(1)) : (round_idx - IDX_W'(1));
          dp_final_d    = ((rnd_cnt + IDX_W'(1)) == nr);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      nr           <= NR_128;
      rnd_cnt      <= '0;
      ready        <= 1'b1;
      key_valid    <= 1'b0;
      result_valid <= 1'b0;
      cmd_err      <= 1'b0;
      kexp_en      <= 1'b0;
      kexp_idx     <= '0;
      dp_load      <= 1'b0;
      dp_round_en  <= 1'b0;
      dp_final     <= 1'b0;
      dp_encdec    <= 1'b0;
      round_idx    <= '0;
`ifdef AES_CTRL_CNT_EN
      blk_count    <= '0;
`endif
    end else begin
      state        <= state_d;
      nr           <= nr_d;
      rnd_cnt      <= rnd_cnt_d;
      ready        <= ready_d;
      key_valid    <= key_valid_d;
      result_valid <= result_valid_d;
      cmd_err      <= cmd_err_d;
      kexp_en      <= kexp_en_d;
      kexp_idx     <= kexp_idx_d;
      dp_load      <= dp_load_d;
      dp_round_en  <= dp_round_en_d;
      dp_final     <= dp_final_d;
      dp_encdec    <= dp_encdec_d;
      round_idx    <= round_idx_d;
`ifdef AES_CTRL_CNT_EN
      blk_count    <= blk_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Scoreboard bench for aes_core_ctrl: per-cycle expected output vectors are queued when a
// command is driven and popped against the DUT on each falling edge.
module tb_aes_core_ctrl;

  localparam int unsigned V_W = 17;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init;
  logic       next;
  logic       encdec;
  logic [3:0] keylen;
  logic       ready;
  logic       key_valid;
  logic       result_valid;
  logic       cmd_err;
  logic       kexp_en;
  logic [3:0] kexp_idx;
  logic       dp_load;
  logic       dp_round_en;
  logic       dp_final;
  logic       dp_encdec;
  logic [3:0] round_idx;
`ifdef AES_CTRL_CNT_EN
  logic [1:0] blk_count;
`endif

  int checks = 0;
  int passed = 0;

  logic [V_W-1:0] exp_q[$];

  // Reference model state
  logic       m_kv;
  logic       m_enc;
  int         m_nr;
  int         m_kidx;
  int         m_ridx;

  always #5 clk = ~clk;

`ifdef AES_CTRL_CNT_EN
  aes_core_ctrl #(.CNT_W(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .next         (next),
    .encdec       (encdec),
    .keylen       (keylen),
    .ready        (ready),
    .key_valid    (key_valid),
    .result_valid (result_valid),
    .cmd_err      (cmd_err),
    .kexp_en      (kexp_en),
    .kexp_idx     (kexp_idx),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .dp_final     (dp_final),
    .dp_encdec    (dp_encdec),
    .round_idx    (round_idx),
    .blk_count    (blk_count)
  );
`else
  aes_core_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .next         (next),
    .encdec       (encdec),
    .keylen       (keylen),
    .ready        (ready),
    .key_valid    (key_valid),
    .result_valid (result_valid),
    .cmd_err      (cmd_err),
    .kexp_en      (kexp_en),
    .kexp_idx     (kexp_idx),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .dp_final     (dp_final),
    .dp_encdec    (dp_encdec),
    .round_idx    (round_idx)
  );
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic logic [V_W-1:0] obs();
    return {ready, key_valid, result_valid, cmd_err, kexp_en, kexp_idx,
            dp_load, dp_round_en, dp_final, dp_encdec, round_idx};
  endfunction

  function automatic logic [V_W-1:0] mk(logic rdy, logic kv, logic rv, logic err, logic ken,
                                        int kidx, logic ld, logic ren, logic fin, logic enc,
                                        int ridx);
    return {rdy, kv, rv, err, ken, 4'(kidx), ld, ren, fin, enc, 4'(ridx)};
  endfunction

  task automatic model_reset();
    m_kv = 1'b0; m_enc = 1'b0; m_nr = 10; m_kidx = 0; m_ridx = 0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic model_idle();
    exp_q.push_back(mk(1, m_kv, 0, 0, 0, m_kidx, 0, 0, 0, m_enc, m_ridx));
  endtask

  task automatic model_err();
    exp_q.push_back(mk(1, m_kv, 0, 1, 0, m_kidx, 0, 0, 0, m_enc, m_ridx));
  endtask

  task automatic model_init(int nr);
    for (int i = 0; i <= nr; i++)
      exp_q.push_back(mk(0, 0, 0, 0, 1, i, 0, 0, 0, m_enc, m_ridx));
    m_nr = nr; m_kidx = nr; m_kv = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 0, 0, m_kidx, 0, 0, 0, m_enc, m_ridx));
  endtask

  task automatic model_next(logic e);
    m_enc = e;
    exp_q.push_back(mk(0, 1, 0, 0, 0, m_kidx, 1, 0, 0, e, e ? 0 : m_nr));
    for (int k = 1; k <= m_nr; k++)
      exp_q.push_back(mk(0, 1, 0, 0, 0, m_kidx, 0, 1, k == m_nr, e, e ? k : m_nr - k));
    m_ridx = e ? m_nr : 0;
    exp_q.push_back(mk(1, 1, 1, 0, 0, m_kidx, 0, 0, 0, e, m_ridx));
  endtask

  // Drop commands and scramble the latched-only inputs.
  task automatic clear_cmd();
    init = 1'b0; next = 1'b0; encdec = ~encdec; keylen = 4'b0011;
  endtask

  task automatic test_reset();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    reset_n = 1'b0; init = 1'b1; next = 1'b1; encdec = 1'b1; keylen = 4'd0;
    repeat (2) @(negedge clk);
    model_reset();
    e = exp_q.pop_front(); got = obs(); checks++;
    if (got !== e) $display("FAIL reset_state: got %h expected %h", got, e); else passed++;
`ifdef AES_CTRL_CNT_EN
    checks++;
    if (blk_count !== 2'd0) $display("FAIL reset_blk_count: got %0d expected 0", blk_count); else passed++;
`endif
    reset_n = 1'b1; init = 1'b0; next = 1'b0;
    model_idle();
    @(negedge clk);
    e = exp_q.pop_front(); got = obs(); checks++;
    if (got !== e) $display("FAIL reset_idle: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_cmd_err();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    next = 1'b1; encdec = 1'b1;
    model_err(); model_idle(); model_err(); model_idle(); model_err(); model_idle();
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL cmd_err cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1 || c == 3 || c == 5) clear_cmd();
      if (c == 2) begin init = 1'b1; keylen = 4'b0011; end
      if (c == 4) begin init = 1'b1; keylen = 4'b1111; end
    end
  endtask

  task automatic test_kexp_128();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    init = 1'b1; keylen = 4'b1100;
    model_init(10);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL kexp_128 cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1) clear_cmd();
    end
  endtask

  task automatic test_encrypt_128();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    next = 1'b1; encdec = 1'b1;
    model_next(1'b1);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL encrypt_128 cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1) clear_cmd();
    end
  endtask

  task automatic test_decrypt_256();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    init = 1'b1; keylen = 4'd2;
    model_init(14);
    model_next(1'b0);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL decrypt_256 cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1 || c == 17) clear_cmd();
      if (c == 16) begin next = 1'b1; encdec = 1'b0; end
    end
  endtask

  task automatic test_init_next_busy();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    init = 1'b1; next = 1'b1; keylen = 4'd0; encdec = 1'b1;
    model_init(10);
    model_next(1'b1);
    model_idle(); model_idle();
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL init_next_busy cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1 || c == 13 || c == 18) clear_cmd();
      if (c == 12) begin next = 1'b1; encdec = 1'b1; end
      if (c == 17) begin next = 1'b1; init = 1'b1; keylen = 4'd2; end
    end
  endtask

  task automatic test_back_to_back();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    next = 1'b1; encdec = 1'b1;
    model_next(1'b1);
    model_next(1'b0);
    model_idle();
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL back_to_back cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1 || c == 13) clear_cmd();
      if (c == 12) begin next = 1'b1; encdec = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_round();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    next = 1'b1; encdec = 1'b1;
    model_next(1'b1);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    model_reset();
    model_idle(); model_idle();
    model_err();
    for (int i = 0; i < 13; i++) model_idle();
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL reset_mid_round cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1 || c == 9) clear_cmd();
      if (c == 5) reset_n = 1'b0;
      if (c == 6) reset_n = 1'b1;
      if (c == 8) begin next = 1'b1; encdec = 1'b1; end
    end
  endtask

`ifdef AES_CTRL_CNT_EN
  task automatic test_blk_count();
    logic [V_W-1:0] got;
    logic [V_W-1:0] e;
    logic [1:0]     cnt_q[$];
    logic [1:0]     ce;
    reset_n = 1'b0; clear_cmd();
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    m_kv = 1'b0; m_enc = 1'b0; m_nr = 10; m_kidx = 0; m_ridx = 0;
    init = 1'b1; keylen = 4'd0;
    model_init(10);
    for (int k = 0; k < 5; k++) begin
      model_next(1'b1);
      cnt_q.push_back(2'((k + 1) % 4));
    end
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL blk_count_seq cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (result_valid === 1'b1 && cnt_q.size() > 0) begin
        ce = cnt_q.pop_front(); checks++;
        if (blk_count !== ce) $display("FAIL blk_count cyc %0d: got %0d expected %0d", c, blk_count, ce);
        else passed++;
      end
      if ((c - 1) % 12 == 0) clear_cmd();
      if (c >= 12 && c < 72 && (c - 12) % 12 == 0) begin next = 1'b1; encdec = 1'b1; end
    end
    checks++;
    if (cnt_q.size() != 0) $display("FAIL blk_count_pulses: got %0d pending expected 0", cnt_q.size());
    else passed++;
    // A fresh key expansion must leave the counter alone.
    init = 1'b1; keylen = 4'd1;
    model_init(12);
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); got = obs(); checks++;
      if (got !== e) $display("FAIL blk_count_init cyc %0d: got %h expected %h", c, got, e); else passed++;
      if (c == 1) clear_cmd();
    end
    checks++;
    if (blk_count !== 2'd1) $display("FAIL blk_count_after_init: got %0d expected 1", blk_count);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_err();
    test_kexp_128();
    test_encrypt_128();
    test_decrypt_256();
    test_init_next_busy();
    test_back_to_back();
    test_reset_mid_round();
`ifdef AES_CTRL_CNT_EN
    test_blk_count();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
